array_mem: RTL and testbench
============================

// Module: array_mem
// PURPOSE
//  8-word x 4-bit register-file memory with a 7-segment readout.
//  - Words are written from data_in and read back by address.
//  - The last word read is shown as a hex digit on led_out.
//  - Standalone board-level lab block; the top level drives switches in and segments out.
// PARAMETERS
//  WIDTH      4  data word width in bits (decoder supports exactly 4)
//  REG_NUM    8  number of words
//  ADDR_BITS  3  address width; REG_NUM == 2**ADDR_BITS
// PORTS
//  clock     in   1          system clock, rising-edge active
//  reset     in   1          asynchronous, active-high reset
//  data_in   in   WIDTH      write data
//  address   in   ADDR_BITS  word select for read and write
//  rw        in   1          0 = write, 1 = read
//  ensure    in   1          operation enable; 0 = idle/hold
//  led_out   out  7          segment drive {g,f,e,d,c,b,a}, bit0 = a
// BEHAVIOUR
//  - Reset is asynchronous and active-high, with one clock domain.
//    - reset=1 clears every memory word and the display register (disp) to 0 immediately.
//    - Result: led_out = 7'h3F ("0").
//  - Write (rising edge, ensure=1, rw=0): mem[address] <= data_in.
//    - disp is unchanged.
//    - Repeated writes to the same address are legal; the last one wins.
//  - Read (rising edge, ensure=1, rw=1): disp <= mem[address].
//    - led_out reflects the new value one cycle after the edge (1-cycle latency).
//    - Reading an address written on the same edge is impossible, because rw selects one operation.
//  - ensure=0: memory and disp hold.
//    - led_out is stable; data_in, address and rw are ignored.
//  - led_out = seg_decode(disp), combinational from the registered disp, so it is glitch-free per cycle.
//  - Segment map: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//  - address always indexes a valid word (8 = 2**3), so there is no out-of-range case.
//  - Reset asserted mid-operation aborts the pending write or read.
//    - The first edge after deassertion operates normally.
// CONFIGURATION
//  SEG_ACTIVE_LOW_EN
//    - Defined: led_out = ~seg_decode(disp), for common-anode displays.
//      Reset value is 7'h40; digit 4 is 7'h19.
//    - Undefined: active-high segments as tabulated above.
// STRUCTURE
//  - Package array_mem_pkg holds:
//    - WIDTH, REG_NUM, ADDR_BITS defaults
//    - SEG_* 7-bit constants for digits 0-F
//    - RW_WRITE=1'b0 / RW_READ=1'b1 constants
//  - Sub-module seg7_decoder: 4-bit in, 7-bit active-high out, purely combinational.
//    The polarity option is applied in array_mem, not in the decoder.
//  - Storage is a reg array [0:REG_NUM-1] plus the disp register; no RAM inference required.
// TESTING
//  1 Reset with no operations -> led_out=7'h3F; reading every address returns 0 (3F).
//  2 Write 0 to addr0 (rw=0), then read addr0 (rw=1) -> led_out=7'h3F one cycle after the read edge.
//  3 Write 4 to addr1 with rw=0 held for many cycles -> led_out stays at prior value;
//    then read addr1 -> 7'h66.
//  4 Write value i^4'hA to addresses 0..7, read back all -> correct segment code each, incl. F -> 7'h71.
//  5 ensure=0 while toggling rw/address/data_in -> memory and led_out unchanged on later reads.
//  6 Assert reset mid-run after writing 7 to addr3 -> led_out=3F at once; read addr3 -> 3F.
//    Repeat 2 with SEG_ACTIVE_LOW_EN -> outputs inverted.

Source files
------------

// File: rtl/array_mem_pkg.sv
// Shared definitions for the array_mem register-file block.
// Holds the default geometry, the 7-segment digit codes (active-high,
// bit order {g,f,e,d,c,b,a}) and the rw encoding.
package array_mem_pkg;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned REG_NUM   = 8;
  localparam int unsigned ADDR_BITS = 3;
  localparam int unsigned SEG_W     = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to 7-segment decoder, purely combinational, active-high.
// Ports:
//   digit  in  WIDTH  hex value 0-F
//   seg_c  out 7      segments {g,f,e,d,c,b,a}, bit0 = a
module seg7_decoder
  import array_mem_pkg::*;
(
  input  logic [WIDTH-1:0] digit,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_0;
    case (digit)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_0;
    endcase
  end

endmodule

// File: rtl/array_mem.sv
// 8-word x 4-bit register-file memory with a 7-segment readout of the
// last word read.
// Ports:
//   clock    in   1          rising-edge clock
//   reset    in   1          asynchronous active-high reset
//   data_in  in   WIDTH      write data
//   address  in   ADDR_BITS  word select for read and write
//   rw       in   1          0 = write, 1 = read
//   ensure   in   1          operation enable; 0 = hold
//   led_out  out  7          segment drive {g,f,e,d,c,b,a}
// Configuration macro SEG_ACTIVE_LOW_EN: when defined, led_out is
// inverted for common-anode displays.
module array_mem
  import array_mem_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 rw,
  input  logic                 ensure,
  output logic [SEG_W-1:0]     led_out
);

  logic [WIDTH-1:0] mem [0:REG_NUM-1];
  logic [WIDTH-1:0] disp;
  logic [SEG_W-1:0] seg;

  // Storage: rw picks exactly one of write or read per enabled edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        mem[i] <= '0;
      end
    end else if (ensure && (rw == RW_WRITE)) begin
      mem[address] <= data_in;
    end
  end

  // Display register: captures the word on a read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp <= '0;
    end else if (ensure && (rw == RW_READ)) begin
      disp <= mem[address];
    end
  end

  seg7_decoder u_seg7_decoder (
    .digit (disp),
    .seg_c (seg)
  );

  // Decoded straight from the registered disp, so led_out only changes
  // once per clock or on reset.
`ifdef SEG_ACTIVE_LOW_EN
  assign led_out = ~seg;
`else
  assign led_out = seg;
`endif

endmodule

// File: tb/tb_array_mem.sv
// Self-checking bench for array_mem: directed scenarios plus a random
// run, each cycle compared against a plain array model of the memory.
module tb_array_mem;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] data_in = '0;
  logic [2:0] address = '0;
  logic       rw = 1'b0;
  logic       ensure = 1'b0;
  logic [6:0] led_out;

  int vectors = 0;
  int miscompares = 0;

  int m_mem [8];
  int m_disp;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  array_mem dut (
    .clock   (clock),
    .reset   (reset),
    .data_in (data_in),
    .address (address),
    .rw      (rw),
    .ensure  (ensure),
    .led_out (led_out)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg_exp(int v);
    logic [6:0] s;
    s = SEG_TBL[v & 15];
`ifdef SEG_ACTIVE_LOW_EN
    s = ~s;
`endif
    return s;
  endfunction

  task automatic chk(string tag, logic [6:0] expected);
    vectors++;
    assert (led_out === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, led_out, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 0;
    m_disp = 0;
  endtask

  // Apply one operation at a negedge, clock it, check at the next negedge.
  task automatic step(string tag, logic en, logic r, int a, int d);
    ensure  = en;
    rw      = r;
    address = 3'(a);
    data_in = 4'(d);
    @(posedge clock);
    if (en) begin
      if (r) m_disp = m_mem[a & 7];
      else   m_mem[a & 7] = d & 15;
    end
    @(negedge clock);
    chk(tag, seg_exp(m_disp));
  endtask

  task automatic wr(int a, int d);
    step("write", 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(string tag, int a);
    step(tag, 1'b1, 1'b1, a, int'($urandom_range(15)));
  endtask

  initial begin
    model_reset();
    // Reset with no operations.
    #2 reset = 1'b1;
    #1 chk("reset_led", seg_exp(0));
    @(negedge clock);
    reset = 1'b0;
    chk("post_reset_led", seg_exp(0));
    for (int i = 0; i < 8; i++) rd("reset_read", i);

    // Write 0 to addr0, read it back.
    wr(0, 0);
    rd("read_zero", 0);

    // Long write to addr1: display holds the previous word.
    wr(2, 9);
    rd("prior_read", 2);
    for (int i = 0; i < 6; i++) step("write_hold", 1'b1, 1'b0, 1, 4);
    rd("read_four", 1);

    // Pattern i ^ 0xA across all words, including F at addr5.
    for (int i = 0; i < 8; i++) wr(i, i ^ 10);
    for (int i = 0; i < 8; i++) rd("pattern_read", i);

    // Idle with toggling inputs: nothing changes.
    for (int i = 0; i < 10; i++)
      step("idle_hold", 1'b0, 1'($urandom_range(1)), int'($urandom_range(7)),
           int'($urandom_range(15)));
    for (int i = 0; i < 8; i++) rd("idle_verify", i);

    // Last write wins.
    wr(6, 3); wr(6, 12);
    rd("last_write", 6);

    // Reset mid-run after writing 7 to addr3; a write held across reset is aborted.
    wr(3, 7);
    rd("pre_reset_read", 3);
    ensure = 1'b1; rw = 1'b0; address = 3'd3; data_in = 4'd9;
    #1 reset = 1'b1;
    model_reset();
    #1 chk("async_reset_led", seg_exp(0));
    @(posedge clock);
    @(negedge clock);
    chk("reset_held_led", seg_exp(0));
    reset = 1'b0;
    rd("read_after_reset", 3);
    wr(0, 0);
    rd("read_zero_again", 0);
    wr(4, 4);
    rd("digit_four", 4);

    // Random run against the model.
    for (int n = 0; n < 300; n++)
      step("random", 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
           int'($urandom_range(7)), int'($urandom_range(15)));
    for (int i = 0; i < 8; i++) rd("final_read", i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
